// File: rtl/mmio_initiator.sv
// Single-outstanding MMIO command initiator: issues write/read strobes to a responder,
// tracks read responses by transaction ID with a timeout, and counts dropped responses.
module mmio_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TID_W          = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [15:0]      cmd_addr,
    input  logic [63:0]      cmd_wdata,
    output logic             mmio_wr_valid,
    output logic             mmio_rd_valid,
    output logic [15:0]      mmio_addr,
    output logic [TID_W-1:0] mmio_tid,
    output logic [63:0]      mmio_wdata,
    input  logic             rsp_valid,
    input  logic [TID_W-1:0] rsp_tid,
    input  logic [63:0]      rsp_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_err,
    output logic [7:0]       stale_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RESULT
    } state_t;

    // Leaving on this count makes res_valid rise TIMEOUT_CYCLES edges after the read strobe.
    localparam logic [15:0] LP_WAIT_END = 16'(TIMEOUT_CYCLES - 2);

    state_t             r_state;
    logic [TID_W-1:0]   r_tid;
    logic [15:0]        r_wait;
    logic               r_cmd_ready;
    logic               r_wr_valid;
    logic               r_rd_valid;
    logic [15:0]        r_addr;
    logic [TID_W-1:0]   r_mmio_tid;
    logic [63:0]        r_wdata;
    logic               r_res_valid;
    logic [63:0]        r_res_data;
    logic               r_res_err;
    logic [7:0]         r_stale;

    state_t             w_state_nxt;
    logic [TID_W-1:0]   w_tid_nxt;
    logic [15:0]        w_wait_nxt;
    logic               w_wr_valid_nxt;
    logic               w_rd_valid_nxt;
    logic [15:0]        w_addr_nxt;
    logic [TID_W-1:0]   w_mmio_tid_nxt;
    logic [63:0]        w_wdata_nxt;
    logic               w_res_valid_nxt;
    logic [63:0]        w_res_data_nxt;
    logic               w_res_err_nxt;
    logic [7:0]         w_stale_nxt;
    logic               w_rsp_match;

    always_comb begin
        w_state_nxt     = r_state;
        w_tid_nxt       = r_tid;
        w_wait_nxt      = r_wait;
        w_wr_valid_nxt  = 1'b0;
        w_rd_valid_nxt  = 1'b0;
        w_addr_nxt      = r_addr;
        w_mmio_tid_nxt  = r_mmio_tid;
        w_wdata_nxt     = r_wdata;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_err_nxt   = r_res_err;
        w_stale_nxt     = r_stale;

        w_rsp_match = (r_state == S_WAIT_RSP) && rsp_valid && (rsp_tid == r_mmio_tid);
        if (rsp_valid && !w_rsp_match && (r_stale != 8'hFF)) begin
            w_stale_nxt = r_stale + 8'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (cmd_addr[0]) begin
                        w_state_nxt     = S_RESULT;
                        w_res_valid_nxt = 1'b1;
                        w_res_data_nxt  = '0;
                        w_res_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_ISSUE;
                        w_addr_nxt     = cmd_addr;
                        w_wdata_nxt    = cmd_wdata;
                        w_mmio_tid_nxt = r_tid;
                        if (cmd_wr) begin
                            w_wr_valid_nxt = 1'b1;
                        end else begin
                            w_rd_valid_nxt = 1'b1;
                            w_tid_nxt      = r_tid + TID_W'(1);
                        end
                    end
                end
            end
            S_ISSUE: begin
                w_wait_nxt  = '0;
                w_state_nxt = r_wr_valid ? S_IDLE : S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                // A matching response beats a timeout landing in the same cycle.
                if (w_rsp_match) begin
                    w_state_nxt     = S_RESULT;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = rsp_data;
                    w_res_err_nxt   = 1'b0;
                end else if (r_wait == LP_WAIT_END) begin
                    w_state_nxt     = S_RESULT;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = '0;
                    w_res_err_nxt   = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 16'd1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tid       <= '0;
            r_wait      <= '0;
            r_cmd_ready <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_addr      <= '0;
            r_mmio_tid  <= '0;
            r_wdata     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_stale     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tid       <= w_tid_nxt;
            r_wait      <= w_wait_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_wr_valid  <= w_wr_valid_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_addr      <= w_addr_nxt;
            r_mmio_tid  <= w_mmio_tid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_err   <= w_res_err_nxt;
            r_stale     <= w_stale_nxt;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign mmio_wr_valid = r_wr_valid;
    assign mmio_rd_valid = r_rd_valid;
    assign mmio_addr     = r_addr;
    assign mmio_tid      = r_mmio_tid;
    assign mmio_wdata    = r_wdata;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_err       = r_res_err;
    assign stale_cnt     = r_stale;

endmodule

// File: tb/tb_mmio_initiator.sv
// Scenario bench for mmio_initiator: expected read results are queued at issue time
// and popped when res_valid appears.
module tb_mmio_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [15:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic        mmio_wr_valid;
    logic        mmio_rd_valid;
    logic [15:0] mmio_addr;
    logic [8:0]  mmio_tid;
    logic [63:0] mmio_wdata;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_err;
    logic [7:0]  stale_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } res_t;

    res_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_seen = 0;
    int          rd_seen = 0;
    logic [8:0]  exp_tid = '0;
    logic [7:0]  exp_stale = '0;

    mmio_initiator #(
        .TIMEOUT_CYCLES(64),
        .TID_W(9)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .mmio_wr_valid(mmio_wr_valid),
        .mmio_rd_valid(mmio_rd_valid),
        .mmio_addr(mmio_addr),
        .mmio_tid(mmio_tid),
        .mmio_wdata(mmio_wdata),
        .rsp_valid(rsp_valid),
        .rsp_tid(rsp_tid),
        .rsp_data(rsp_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_err(res_err),
        .stale_cnt(stale_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mmio_wr_valid) wr_seen++;
        if (mmio_rd_valid) rd_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        exp_tid   = '0;
        exp_stale = '0;
    endtask

    // Leaves the bench in the cycle right after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] wd);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_rsp(input logic [8:0] tid, input logic [63:0] d);
        rsp_valid = 1'b1;
        rsp_tid   = tid;
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic wait_result(output logic found, output int cycles);
        found  = 1'b0;
        cycles = 0;
        while (res_valid !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        checks++;
        if (res_valid === 1'b1) found = 1'b1;
        else begin
            errors++;
            $display("FAIL res_wait: res_valid=%b required 1 within 200 cycles", res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({mmio_wr_valid, mmio_rd_valid, res_valid, res_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: wr/rd/res_valid/err=%b required 0000",
                     {mmio_wr_valid, mmio_rd_valid, res_valid, res_err});
        end
        checks++;
        if ({mmio_addr, mmio_tid, mmio_wdata, res_data, stale_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h tid=%h wdata=%h res_data=%h stale=%h required 0",
                     mmio_addr, mmio_tid, mmio_wdata, res_data, stale_cnt);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        int wr0 = wr_seen;
        send_cmd(1'b1, 16'h0020, 64'hDEADBEEF_0000_0001);
        checks++;
        if ({mmio_wr_valid, mmio_rd_valid} !== 2'b10) begin
            errors++;
            $display("FAIL write_strobe: wr,rd=%b required 10", {mmio_wr_valid, mmio_rd_valid});
        end
        checks++;
        if (mmio_addr !== 16'h0020 || mmio_wdata !== 64'hDEADBEEF_0000_0001 || mmio_tid !== exp_tid) begin
            errors++;
            $display("FAIL write_fields: addr=%h wdata=%h tid=%h required 0020 deadbeef00000001 %h",
                     mmio_addr, mmio_wdata, mmio_tid, exp_tid);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_busy: cmd_ready=%b required 0", cmd_ready);
        end
        tick();
        checks++;
        if ({mmio_wr_valid, cmd_ready, res_valid} !== 3'b010) begin
            errors++;
            $display("FAIL write_done: wr_valid,cmd_ready,res_valid=%b required 010",
                     {mmio_wr_valid, cmd_ready, res_valid});
        end
        tick();
        checks++;
        if (wr_seen - wr0 != 1) begin
            errors++;
            $display("FAIL write_one_cycle: strobes=%0d required 1", wr_seen - wr0);
        end
    endtask

    task automatic test_read();
        logic found;
        int   cyc;
        res_t got, exp;
        for (int k = 0; k < 2; k++) begin
            logic [63:0] d = (k == 0) ? 64'h1234 : 64'h0BAD_CAFE_0000_5678;
            send_cmd(1'b0, 16'h0020, '0);
            checks++;
            if (mmio_rd_valid !== 1'b1 || mmio_tid !== exp_tid) begin
                errors++;
                $display("FAIL read_issue: rd_valid=%b tid=%h required 1 %h", mmio_rd_valid, mmio_tid, exp_tid);
            end
            sb.push_back('{data: d, err: 1'b0});
            repeat (3) tick();
            drive_rsp(exp_tid, d);
            exp_tid++;
            wait_result(found, cyc);
            got = {res_data, res_err};
            exp = sb.pop_front();
            if (found) begin
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL read_result: data=%h err=%b required %h %b", got.data, got.err, exp.data, exp.err);
                end
            end
            tick();
            checks++;
            if (res_valid !== 1'b0 || stale_cnt !== exp_stale) begin
                errors++;
                $display("FAIL read_consume: res_valid=%b stale=%0d required 0 %0d", res_valid, stale_cnt, exp_stale);
            end
        end
    endtask

    task automatic test_timeout();
        logic found;
        int   cyc;
        logic [8:0] t;
        res_t exp;
        send_cmd(1'b0, 16'h0040, '0);
        t = exp_tid;
        exp_tid++;
        sb.push_back('{data: 64'h0, err: 1'b1});
        wait_result(found, cyc);
        exp = sb.pop_front();
        checks++;
        if (cyc != 64) begin
            errors++;
            $display("FAIL timeout_latency: cycles=%0d required 64", cyc);
        end
        checks++;
        if ({res_data, res_err} !== exp) begin
            errors++;
            $display("FAIL timeout_result: data=%h err=%b required %h %b", res_data, res_err, exp.data, exp.err);
        end
        tick();
        drive_rsp(t, 64'hFFFF);
        exp_stale++;
        checks++;
        if (stale_cnt !== exp_stale) begin
            errors++;
            $display("FAIL timeout_late_stale: stale=%0d required %0d", stale_cnt, exp_stale);
        end
    endtask

    task automatic test_timeout_race();
        logic found;
        int   cyc;
        res_t exp;
        send_cmd(1'b0, 16'h0044, '0);
        sb.push_back('{data: 64'h7777_0000_1111_2222, err: 1'b0});
        repeat (63) tick();
        drive_rsp(exp_tid, 64'h7777_0000_1111_2222);
        exp_tid++;
        wait_result(found, cyc);
        exp = sb.pop_front();
        checks++;
        if ({res_data, res_err} !== exp || cyc != 0) begin
            errors++;
            $display("FAIL race_match_wins: data=%h err=%b extra=%0d required %h %b 0",
                     res_data, res_err, cyc, exp.data, exp.err);
        end
        tick();
    endtask

    task automatic test_misaligned();
        int   s0 = wr_seen + rd_seen;
        res_t exp;
        res_ready = 1'b0;
        sb.push_back('{data: 64'h0, err: 1'b1});
        send_cmd(1'b0, 16'h0021, '0);
        exp = sb.pop_front();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (res_valid !== 1'b1 || {res_data, res_err} !== exp || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_hold[%0d]: res_valid=%b data=%h err=%b cmd_ready=%b required 1 %h %b 0",
                         k, res_valid, res_data, res_err, cmd_ready, exp.data, exp.err);
            end
            if (k < 5) tick();
        end
        res_ready = 1'b1;
        tick();
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_release: res_valid=%b cmd_ready=%b required 0 1", res_valid, cmd_ready);
        end
        checks++;
        if (wr_seen + rd_seen != s0) begin
            errors++;
            $display("FAIL misaligned_no_strobe: strobes=%0d required 0", wr_seen + rd_seen - s0);
        end
    endtask

    task automatic test_back_to_back();
        logic found;
        int   cyc;
        res_t exp;
        apply_reset();
        for (int i = 0; i <= 512; i++) begin
            logic [63:0] d = 64'hC0DE_0000_0000_0000 | 64'(i);
            send_cmd(1'b0, 16'h0100, '0);
            checks++;
            if (mmio_tid !== exp_tid) begin
                errors++;
                $display("FAIL b2b_tid[%0d]: tid=%0d required %0d", i, mmio_tid, exp_tid);
            end
            tick();
            if (i == 5) begin
                drive_rsp(exp_tid + 9'd7, 64'hBAD);
                exp_stale++;
            end
            sb.push_back('{data: d, err: 1'b0});
            drive_rsp(exp_tid, d);
            exp_tid++;
            wait_result(found, cyc);
            exp = sb.pop_front();
            if (found) begin
                checks++;
                if ({res_data, res_err} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: data=%h err=%b required %h %b", i, res_data, res_err, exp.data, exp.err);
                end
            end
            tick();
        end
        checks++;
        if (stale_cnt !== exp_stale) begin
            errors++;
            $display("FAIL b2b_stale: stale=%0d required %0d", stale_cnt, exp_stale);
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        int   cyc;
        logic [8:0] old;
        int   rv = 0;
        res_t exp;
        send_cmd(1'b0, 16'h0200, '0);
        old = exp_tid;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({mmio_wr_valid, mmio_rd_valid, res_valid, res_err, mmio_addr, mmio_tid, mmio_wdata, res_data, stale_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rd=%b res_valid=%b addr=%h tid=%h stale=%0d required all 0",
                     mmio_rd_valid, res_valid, mmio_addr, mmio_tid, stale_cnt);
        end
        rst_n = 1'b1;
        exp_tid   = '0;
        exp_stale = '0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: cmd_ready=%b required 1", cmd_ready);
        end
        drive_rsp(old, 64'h5555);
        exp_stale++;
        for (int k = 0; k < 8; k++) begin
            if (res_valid === 1'b1) rv++;
            tick();
        end
        checks++;
        if (rv != 0 || stale_cnt !== exp_stale) begin
            errors++;
            $display("FAIL midreset_abandon: res_valid_cycles=%0d stale=%0d required 0 %0d", rv, stale_cnt, exp_stale);
        end
        send_cmd(1'b0, 16'h0200, '0);
        checks++;
        if (mmio_tid !== exp_tid) begin
            errors++;
            $display("FAIL midreset_tid: tid=%0d required %0d", mmio_tid, exp_tid);
        end
        tick();
        sb.push_back('{data: 64'h99, err: 1'b0});
        drive_rsp(exp_tid, 64'h99);
        exp_tid++;
        wait_result(found, cyc);
        exp = sb.pop_front();
        if (found) begin
            checks++;
            if ({res_data, res_err} !== exp) begin
                errors++;
                $display("FAIL midreset_read: data=%h err=%b required %h %b", res_data, res_err, exp.data, exp.err);
            end
        end
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_valid = 1'b0;
        rsp_tid   = '0;
        rsp_data  = '0;
        res_ready = 1'b1;
        #1;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_timeout_race();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
